reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
// - Holds decoded ops dispatched by the reorder buffer until both source operands are available, then issues them to the ALU.
// - Sits between ROB dispatch (op/value/query/target) and the ALU; snoops the ALU and memory result broadcasts to wake waiting operands.
// - Tag 0 means "no tag / operand ready" everywhere.
// PARAMETERS
// - DEPTH   4   number of entries (2..8)
// - TAG_W   3   ROB tag width
// - OP_W    5   opcode width; all-ones (5'b11111) = no op
// - XLEN    32  data width
// PORTS
// - clk        in   1      clock
// - rst        in   1      reset, synchronous, active-low
// - op_in      in   OP_W   dispatched opcode; 5'b11111 = none this cycle
// - v1_in      in   XLEN   operand 1 value, valid when q1_in==0
// - v2_in      in   XLEN   operand 2 value, valid when q2_in==0
// - q1_in      in   TAG_W  ROB tag producing operand 1; 0 = ready
// - q2_in      in   TAG_W  ROB tag producing operand 2; 0 = ready
// - imm_in     in   XLEN   immediate, passed through unchanged
// - dest_in    in   TAG_W  ROB entry of this op (nonzero when op_in valid)
// - alu_tag    in   TAG_W  ALU broadcast tag; 0 = none
// - alu_res    in   XLEN   ALU broadcast value
// - mem_tag    in   TAG_W  memory broadcast tag; 0 = none
// - mem_res    in   XLEN   memory broadcast value
// - rs_full    out  1      entries in use >= DEPTH-1; upstream must stop dispatch
// - iss_op     out  OP_W   issued opcode; 5'b11111 = no issue
// - iss_a      out  XLEN   issued operand 1
// - iss_b      out  XLEN   issued operand 2
// - iss_imm    out  XLEN   issued immediate
// - iss_dest   out  TAG_W  issued ROB tag; 0 when no issue
// - ovf_err    out  1      sticky: dispatch arrived with all entries busy
// BEHAVIOUR
// - Reset (rst==0 at posedge): all entries invalid, rs_full=0, iss_op=5'b11111, iss_dest=0, iss_a/b/imm=0, ovf_err=0. Overrides every other event that cycle.
// - Entry: busy, op, v1, q1, v2, q2, imm, dest. Ready = busy && q1==0 && q2==0.
// - Allocate: op_in!=5'b11111 writes the lowest-index free entry at posedge.
// - Dispatch bypass: if q1_in (q2_in) nonzero and equals alu_tag or mem_tag that same cycle, store broadcast value and q=0.
// - Wakeup: each busy entry with q1/q2 matching alu_tag or mem_tag (nonzero) captures the value, q<=0, at posedge.
// - Same tag on both buses: ALU value wins.
// - Issue: each cycle pick the lowest-index Ready entry (state before this edge); register its fields onto iss_* at posedge and clear busy. Latency: an op ready at dispatch issues on the 2nd posedge after dispatch; a woken op issues 1 cycle after the wakeup edge.
// - No Ready entry: iss_op=5'b11111, iss_dest=0; iss_a/b/imm hold.
// - Allocation and issue in the same cycle are both performed; freed slot reusable next cycle.
// - Full/overflow: rs_full registered from next-state count (>= DEPTH-1). Dispatch with all DEPTH busy: op dropped, ovf_err<=1 (cleared only by reset).
// - Entries are never reordered; issue is not strictly age-ordered (lowest index wins).
// CONFIGURATION
// - RS_FLUSH_EN defined: adds input port flush (1 bit, after rst). flush==1 at posedge clears all busy bits, forces iss_op=5'b11111/iss_dest=0, ignores op_in that cycle; ovf_err unaffected. Reset has priority over flush.
// - RS_FLUSH_EN undefined: no flush port; entries drain only by issue.
// TESTING
// - Reset: rst=0 one cycle -> rs_full=0, iss_op=5'b11111, iss_dest=0, ovf_err=0.
// - Ready dispatch: op=ADD(0), v1=5, v2=7, q1=q2=0, dest=2 -> two edges later iss_op=0, iss_a=5, iss_b=7, iss_dest=2, then iss_op=5'b11111.
// - Wakeup: dispatch q1=3, dest=4; later alu_tag=3, alu_res=32'h10 -> next cycle iss_a=32'h10, iss_dest=4.
// - Bypass + priority: dispatch q2=5 while alu_tag=5 (res 9) and mem_tag=5 (res 1) -> issued iss_b=9.
// - Fill: dispatch 3 ops with q1=6 (DEPTH=4) -> rs_full=1; 5th dispatch after 4 busy -> dropped, ovf_err=1; broadcast tag 6 -> issues in index order on 4 consecutive cycles, rs_full=0.
// - RS_FLUSH_EN: 2 waiting entries, flush=1 with op_in valid -> no issue, rs_full=0, later alu broadcast issues nothing.

Source files
------------

// File: rtl/reservation_station.sv
// reservation_station: buffers dispatched ops until both source operands are
// available, snooping the ALU and memory result buses, and issues the
// lowest-index ready entry to the ALU each cycle.
// Optional feature: define RS_FLUSH_EN to add a flush input that empties the
// station in one cycle.
module reservation_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3,
    parameter int OP_W  = 5,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
`ifdef RS_FLUSH_EN
    input  logic             flush,
`endif
    input  logic [OP_W-1:0]  op_in,
    input  logic [XLEN-1:0]  v1_in,
    input  logic [XLEN-1:0]  v2_in,
    input  logic [TAG_W-1:0] q1_in,
    input  logic [TAG_W-1:0] q2_in,
    input  logic [XLEN-1:0]  imm_in,
    input  logic [TAG_W-1:0] dest_in,
    input  logic [TAG_W-1:0] alu_tag,
    input  logic [XLEN-1:0]  alu_res,
    input  logic [TAG_W-1:0] mem_tag,
    input  logic [XLEN-1:0]  mem_res,
    output logic             rs_full,
    output logic [OP_W-1:0]  iss_op,
    output logic [XLEN-1:0]  iss_a,
    output logic [XLEN-1:0]  iss_b,
    output logic [XLEN-1:0]  iss_imm,
    output logic [TAG_W-1:0] iss_dest,
    output logic             ovf_err
);
    localparam logic [OP_W-1:0] NO_OP = '1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Entry storage
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [OP_W-1:0]  op_q   [DEPTH];
    logic [OP_W-1:0]  op_d   [DEPTH];
    logic [XLEN-1:0]  v1_q   [DEPTH];
    logic [XLEN-1:0]  v1_d   [DEPTH];
    logic [XLEN-1:0]  v2_q   [DEPTH];
    logic [XLEN-1:0]  v2_d   [DEPTH];
    logic [TAG_W-1:0] q1_q   [DEPTH];
    logic [TAG_W-1:0] q1_d   [DEPTH];
    logic [TAG_W-1:0] q2_q   [DEPTH];
    logic [TAG_W-1:0] q2_d   [DEPTH];
    logic [XLEN-1:0]  imm_q  [DEPTH];
    logic [XLEN-1:0]  imm_d  [DEPTH];
    logic [TAG_W-1:0] dest_q [DEPTH];
    logic [TAG_W-1:0] dest_d [DEPTH];

    // Output registers
    logic             rs_full_q, rs_full_d;
    logic [OP_W-1:0]  iss_op_q, iss_op_d;
    logic [XLEN-1:0]  iss_a_q, iss_a_d;
    logic [XLEN-1:0]  iss_b_q, iss_b_d;
    logic [XLEN-1:0]  iss_imm_q, iss_imm_d;
    logic [TAG_W-1:0] iss_dest_q, iss_dest_d;
    logic             ovf_q, ovf_d;

    logic             iss_hit, free_hit;
    logic [IDX_W-1:0] iss_idx, free_idx;
    logic [CNT_W-1:0] busy_cnt;
    logic             flush_w;

`ifdef RS_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // A waiting tag (nonzero) is satisfied by either broadcast bus.
    function automatic logic tag_hit(input logic [TAG_W-1:0] q,
                                     input logic [TAG_W-1:0] at,
                                     input logic [TAG_W-1:0] mt);
        return (q != '0) && ((q == at) || (q == mt));
    endfunction

    // When both buses carry the same tag the ALU value is taken.
    function automatic logic [XLEN-1:0] tag_val(input logic [TAG_W-1:0] q,
                                                input logic [TAG_W-1:0] at,
                                                input logic [XLEN-1:0]  ar,
                                                input logic [XLEN-1:0]  mr);
        return (q == at) ? ar : mr;
    endfunction

    // Select the lowest-index ready entry to issue and lowest-index free slot.
    always_comb begin
        iss_hit  = 1'b0;
        iss_idx  = '0;
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (busy_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0)) begin
                iss_hit = 1'b1;
                iss_idx = IDX_W'(i);
            end
            if (!busy_q[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Next state: wakeup, issue, allocation, flush and occupancy tracking.
    always_comb begin
        busy_d     = busy_q;
        op_d       = op_q;
        v1_d       = v1_q;
        v2_d       = v2_q;
        q1_d       = q1_q;
        q2_d       = q2_q;
        imm_d      = imm_q;
        dest_d     = dest_q;
        iss_op_d   = NO_OP;
        iss_dest_d = '0;
        iss_a_d    = iss_a_q;
        iss_b_d    = iss_b_q;
        iss_imm_d  = iss_imm_q;
        ovf_d      = ovf_q;
        busy_cnt   = '0;

        // Waiting entries capture broadcast results.
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && tag_hit(q1_q[i], alu_tag, mem_tag)) begin
                v1_d[i] = tag_val(q1_q[i], alu_tag, alu_res, mem_res);
                q1_d[i] = '0;
            end
            if (busy_q[i] && tag_hit(q2_q[i], alu_tag, mem_tag)) begin
                v2_d[i] = tag_val(q2_q[i], alu_tag, alu_res, mem_res);
                q2_d[i] = '0;
            end
        end

        if (flush_w) begin
            busy_d = '0;
        end else begin
            if (iss_hit) begin
                busy_d[iss_idx] = 1'b0;
                iss_op_d        = op_q[iss_idx];
                iss_a_d         = v1_q[iss_idx];
                iss_b_d         = v2_q[iss_idx];
                iss_imm_d       = imm_q[iss_idx];
                iss_dest_d      = dest_q[iss_idx];
            end
            if (op_in != NO_OP) begin
                if (free_hit) begin
                    busy_d[free_idx] = 1'b1;
                    op_d[free_idx]   = op_in;
                    imm_d[free_idx]  = imm_in;
                    dest_d[free_idx] = dest_in;
                    v1_d[free_idx]   = v1_in;
                    q1_d[free_idx]   = q1_in;
                    v2_d[free_idx]   = v2_in;
                    q2_d[free_idx]   = q2_in;
                    if (tag_hit(q1_in, alu_tag, mem_tag)) begin
                        v1_d[free_idx] = tag_val(q1_in, alu_tag, alu_res, mem_res);
                        q1_d[free_idx] = '0;
                    end
                    if (tag_hit(q2_in, alu_tag, mem_tag)) begin
                        v2_d[free_idx] = tag_val(q2_in, alu_tag, alu_res, mem_res);
                        q2_d[free_idx] = '0;
                    end
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end

        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt = busy_cnt + CNT_W'(busy_d[i]);
        end
        rs_full_d = (busy_cnt >= CNT_W'(DEPTH - 1));
    end

    // Control and issue-output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q     <= '0;
            rs_full_q  <= 1'b0;
            iss_op_q   <= NO_OP;
            iss_a_q    <= '0;
            iss_b_q    <= '0;
            iss_imm_q  <= '0;
            iss_dest_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            rs_full_q  <= rs_full_d;
            iss_op_q   <= iss_op_d;
            iss_a_q    <= iss_a_d;
            iss_b_q    <= iss_b_d;
            iss_imm_q  <= iss_imm_d;
            iss_dest_q <= iss_dest_d;
            ovf_q      <= ovf_d;
        end
    end

    // Entry payload registers; contents are meaningless while busy is clear.
    always_ff @(posedge clk) begin
        op_q   <= op_d;
        v1_q   <= v1_d;
        v2_q   <= v2_d;
        q1_q   <= q1_d;
        q2_q   <= q2_d;
        imm_q  <= imm_d;
        dest_q <= dest_d;
    end

    assign rs_full  = rs_full_q;
    assign iss_op   = iss_op_q;
    assign iss_a    = iss_a_q;
    assign iss_b    = iss_b_q;
    assign iss_imm  = iss_imm_q;
    assign iss_dest = iss_dest_q;
    assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed plus random stimulus; a reference model
// queues expected issues, and a monitor compares DUT outputs each cycle.
module tb_reservation_station;
    localparam int DEPTH = 4;
    localparam logic [4:0] NO_OP = 5'b11111;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [4:0]  op_in = NO_OP;
    logic [31:0] v1_in = '0, v2_in = '0, imm_in = '0, alu_res = '0, mem_res = '0;
    logic [2:0]  q1_in = '0, q2_in = '0, dest_in = '0, alu_tag = '0, mem_tag = '0;
    logic        rs_full, ovf_err;
    logic [4:0]  iss_op;
    logic [31:0] iss_a, iss_b, iss_imm;
    logic [2:0]  iss_dest;

    reservation_station #(.DEPTH(DEPTH), .TAG_W(3), .OP_W(5), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
`ifdef RS_FLUSH_EN
        .flush(flush),
`endif
        .op_in(op_in), .v1_in(v1_in), .v2_in(v2_in), .q1_in(q1_in), .q2_in(q2_in),
        .imm_in(imm_in), .dest_in(dest_in), .alu_tag(alu_tag), .alu_res(alu_res),
        .mem_tag(mem_tag), .mem_res(mem_res), .rs_full(rs_full), .iss_op(iss_op),
        .iss_a(iss_a), .iss_b(iss_b), .iss_imm(iss_imm), .iss_dest(iss_dest),
        .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  op;
        logic [31:0] a, b, imm;
        logic [2:0]  dest;
    } iss_t;

    typedef struct {
        bit          busy;
        logic [4:0]  op;
        logic [31:0] v1, v2, imm;
        logic [2:0]  q1, q2, dest;
    } ent_t;

    iss_t        sb[$];
    ent_t        m[DEPTH];
    bit          exp_full = 0, exp_ovf = 0, exp_iss = 0;
    logic [31:0] hold_a = '0, hold_b = '0, hold_imm = '0;
    int          n_total = 0, n_pass = 0;
    bit          mon_en = 0;

    // Resolve one operand against the broadcast buses (ALU first).
    task automatic resolve(inout logic [31:0] v, inout logic [2:0] q);
        if (q != 0 && q == alu_tag) begin v = alu_res; q = 0; end
        else if (q != 0 && q == mem_tag) begin v = mem_res; q = 0; end
    endtask

    // Reference model: one clock edge of the station's documented behaviour.
    task automatic model_step();
        int pick, slot, used;
        ent_t e;
        if (!rst) begin
            foreach (m[i]) m[i].busy = 0;
            sb.delete();
            exp_full = 0; exp_ovf = 0; exp_iss = 0;
            hold_a = 0; hold_b = 0; hold_imm = 0;
            return;
        end
        if (flush) begin
            foreach (m[i]) m[i].busy = 0;
            exp_iss = 0;
        end else begin
            pick = -1; slot = -1;
            foreach (m[i]) if (pick < 0 && m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) pick = i;
            foreach (m[i]) if (slot < 0 && !m[i].busy) slot = i;
            exp_iss = (pick >= 0);
            if (pick >= 0) begin
                sb.push_back('{m[pick].op, m[pick].v1, m[pick].v2, m[pick].imm, m[pick].dest});
                hold_a = m[pick].v1; hold_b = m[pick].v2; hold_imm = m[pick].imm;
                m[pick].busy = 0;
            end
            if (op_in != NO_OP) begin
                if (slot < 0) exp_ovf = 1;
                else m[slot] = '{1, op_in, v1_in, v2_in, imm_in, q1_in, q2_in, dest_in};
            end
            foreach (m[i]) if (m[i].busy) begin
                e = m[i];
                resolve(e.v1, e.q1);
                resolve(e.v2, e.q2);
                m[i] = e;
            end
        end
        used = 0;
        foreach (m[i]) used += m[i].busy;
        exp_full = (used >= DEPTH - 1);
    endtask

    always @(posedge clk) model_step();

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Monitor: compare DUT state against the model, popping issued ops.
    always @(negedge clk) begin
        iss_t x;
        if (mon_en) begin
            chk("rs_full", 32'(rs_full), 32'(exp_full));
            chk("ovf_err", 32'(ovf_err), 32'(exp_ovf));
            chk("issue_valid", 32'(iss_op != NO_OP), 32'(exp_iss));
            if (iss_op != NO_OP) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_issue: got op %0h expected none at %0t", iss_op, $time);
                end else begin
                    x = sb.pop_front();
                    chk("iss_op", 32'(iss_op), 32'(x.op));
                    chk("iss_a", iss_a, x.a);
                    chk("iss_b", iss_b, x.b);
                    chk("iss_imm", iss_imm, x.imm);
                    chk("iss_dest", 32'(iss_dest), 32'(x.dest));
                end
            end else begin
                chk("idle_dest", 32'(iss_dest), 32'd0);
                chk("hold_a", iss_a, hold_a);
                chk("hold_b", iss_b, hold_b);
                chk("hold_imm", iss_imm, hold_imm);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        op_in = NO_OP; q1_in = 0; q2_in = 0; alu_tag = 0; mem_tag = 0; flush = 0;
    endtask

    task automatic disp(input logic [4:0] op, input logic [31:0] v1, input logic [2:0] q1,
                        input logic [31:0] v2, input logic [2:0] q2, input logic [2:0] dest);
        op_in = op; v1_in = v1; q1_in = q1; v2_in = v2; q2_in = q2; dest_in = dest;
        imm_in = $urandom;
    endtask

    initial begin
        idle();
        rst = 0;
        cyc();
        mon_en = 1;
        rst = 1;
        cyc();

        // Ready dispatch
        disp(5'd0, 32'd5, 3'd0, 32'd7, 3'd0, 3'd2); cyc();
        idle(); repeat (3) cyc();

        // Wakeup via ALU
        disp(5'd1, 32'd0, 3'd3, 32'd8, 3'd0, 3'd4); cyc();
        idle(); cyc();
        alu_tag = 3; alu_res = 32'h10; cyc();
        idle(); repeat (2) cyc();

        // Dispatch bypass with same tag on both buses
        disp(5'd2, 32'd1, 3'd0, 32'd0, 3'd5, 3'd5);
        alu_tag = 5; alu_res = 32'd9; mem_tag = 5; mem_res = 32'd1; cyc();
        idle(); repeat (2) cyc();

        // Wakeup via memory bus
        disp(5'd3, 32'd0, 3'd2, 32'd0, 3'd1, 3'd6); cyc();
        idle(); mem_tag = 2; mem_res = 32'hABCD; alu_tag = 1; alu_res = 32'h77; cyc();
        idle(); repeat (2) cyc();

        // Fill, overflow, then drain in index order
        for (int i = 0; i < 5; i++) begin
            disp(5'(4 + i), 32'(i), 3'd6, 32'(100 + i), 3'd0, 3'(i + 1)); cyc();
        end
        idle(); cyc();
        alu_tag = 6; alu_res = 32'h600; cyc();
        idle(); repeat (6) cyc();

`ifdef RS_FLUSH_EN
        rst = 0; cyc(); rst = 1;
        disp(5'd1, 32'd0, 3'd7, 32'd0, 3'd0, 3'd1); cyc();
        disp(5'd2, 32'd0, 3'd7, 32'd0, 3'd0, 3'd2); cyc();
        disp(5'd3, 32'd3, 3'd0, 32'd3, 3'd0, 3'd3); flush = 1; cyc();
        idle(); alu_tag = 7; alu_res = 32'h55; cyc();
        idle(); repeat (3) cyc();
`endif

        // Randomized traffic, with a reset before each block
        for (int blk = 0; blk < 3; blk++) begin
            idle(); rst = 0; cyc(); rst = 1;
            for (int c = 0; c < 300; c++) begin
                idle();
                if ($urandom_range(0, 99) < (rs_full ? 20 : 60))
                    disp(5'($urandom_range(0, 30)), $urandom,
                         $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(1, 7)), $urandom,
                         $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(1, 7)),
                         3'($urandom_range(1, 7)));
                if ($urandom_range(0, 2) == 0) begin
                    alu_tag = 3'($urandom_range(0, 7)); alu_res = $urandom;
                end
                if ($urandom_range(0, 2) == 0) begin
                    mem_tag = ($urandom_range(0, 3) == 0) ? alu_tag : 3'($urandom_range(0, 7));
                    mem_res = $urandom;
                end
`ifdef RS_FLUSH_EN
                flush = ($urandom_range(0, 49) == 0);
`endif
                cyc();
            end
            idle();
            for (int t = 1; t < 8; t++) begin
                alu_tag = 3'(t); alu_res = $urandom; cyc();
            end
            idle(); repeat (6) cyc();
        end

        n_total++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
